// File: rtl/data_table_engine_sched.sv
// Data-table front-end scheduler: serialises search/insert/delete tasks and
// grants the single data-RAM port to whichever engine owns the current task.
package data_table_engine_sched_pkg;
   localparam int TABLE_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      OP_SEARCH = 2'd0,
      OP_INSERT = 2'd1,
      OP_DELETE = 2'd2,
      OP_NOP    = 2'd3
   } ht_opcode_e;

   typedef struct packed {
      ht_opcode_e  opcode;
      logic [15:0] key;
      logic [31:0] value;
   } ht_cmd_t;

   typedef struct packed {
      ht_cmd_t                     cmd;
      logic [TABLE_ADDR_WIDTH-1:0] bucket;
   } ht_pdata_t;

   typedef struct packed {
      logic                        found;
      logic [TABLE_ADDR_WIDTH-1:0] addr;
      logic [31:0]                 value;
   } ht_result_t;

   typedef logic [47:0] ram_data_t;
endpackage

module data_table_engine_sched
   import data_table_engine_sched_pkg::*;
#(
   parameter int RAM_LATENCY    = 2,
   parameter int A_WIDTH        = TABLE_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  ht_pdata_t                      task_i,
   input  logic                           task_valid_i,
   output logic                           task_ready_o,
   output ht_pdata_t                      eng_task_o,
   output logic [2:0]                     eng_task_valid_o,
   input  logic [2:0]                     eng_task_ready_i,
   input  ht_result_t [2:0]               eng_result_i,
   input  logic [2:0]                     eng_result_valid_i,
   output logic [2:0]                     eng_result_ready_o,
   input  logic [2:0][A_WIDTH-1:0]        eng_rd_addr_i,
   input  logic [2:0]                     eng_rd_en_i,
   input  logic [2:0][A_WIDTH-1:0]        eng_wr_addr_i,
   input  ram_data_t [2:0]                eng_wr_data_i,
   input  logic [2:0]                     eng_wr_en_i,
   output logic [A_WIDTH-1:0]             rd_addr_o,
   output logic                           rd_en_o,
   output logic [A_WIDTH-1:0]             wr_addr_o,
   output ram_data_t                      wr_data_o,
   output logic                           wr_en_o,
   output ht_result_t                     result_o,
   output logic                           result_valid_o,
   input  logic                           result_ready_i,
   output logic                           bad_opcode_o,
   output logic                           conflict_o,
   output logic                           timeout_o
);
   localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE_S, DISPATCH_S, BUSY_S, RESULT_S} state_e;

   state_e        r_state, w_state_nxt;
   logic [2:0]    r_owner, w_owner_nxt;   // one-hot; zero whenever no engine owns the RAM
   ht_pdata_t     r_task;
   ht_result_t    r_result;
   logic          r_bad_opcode, r_conflict, r_timeout;
   logic [CW-1:0] r_wd_cnt;
   logic [2:0]    w_sel, w_req;
   logic          w_accept, w_capture;
   ht_result_t    w_owner_result;
   logic          w_unused;

   assign w_unused = (RAM_LATENCY != 0);

   always_comb begin
      w_sel = '0;
      case (task_i.cmd.opcode)
         OP_SEARCH: w_sel = 3'b001;
         OP_INSERT: w_sel = 3'b010;
         OP_DELETE: w_sel = 3'b100;
         default:   w_sel = '0;
      endcase
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_owner_nxt        = r_owner;
      w_accept           = 1'b0;
      w_capture          = 1'b0;
      task_ready_o       = 1'b0;
      eng_task_valid_o   = '0;
      eng_result_ready_o = '0;
      result_valid_o     = 1'b0;
      unique case (r_state)
         IDLE_S: begin
            task_ready_o = 1'b1;
            w_accept     = task_valid_i;
            if (task_valid_i && (w_sel != '0)) begin
               w_owner_nxt = w_sel;
               w_state_nxt = DISPATCH_S;
            end
         end
         DISPATCH_S: begin
            eng_task_valid_o = r_owner;
            if ((eng_task_ready_i & r_owner) != '0) w_state_nxt = BUSY_S;
         end
         BUSY_S: begin
            eng_result_ready_o = r_owner;
            if ((eng_result_valid_i & r_owner) != '0) begin
               w_capture   = 1'b1;
               w_owner_nxt = '0;
               w_state_nxt = RESULT_S;
            end
         end
         RESULT_S: begin
            result_valid_o = 1'b1;
            if (result_ready_i) w_state_nxt = IDLE_S;
         end
         default: w_state_nxt = IDLE_S;
      endcase
   end

   // Owner is non-zero only in DISPATCH_S/BUSY_S, so the mux idles at zero elsewhere.
   always_comb begin
      w_owner_result = '0;
      rd_addr_o      = '0;
      rd_en_o        = 1'b0;
      wr_addr_o      = '0;
      wr_data_o      = '0;
      wr_en_o        = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (r_owner[i]) begin
            w_owner_result = eng_result_i[i];
            rd_addr_o      = eng_rd_addr_i[i];
            rd_en_o        = eng_rd_en_i[i];
            wr_addr_o      = eng_wr_addr_i[i];
            wr_data_o      = eng_wr_data_i[i];
            wr_en_o        = eng_wr_en_i[i];
         end
      end
   end

   assign w_req = eng_rd_en_i | eng_wr_en_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= IDLE_S;
         r_owner      <= '0;
         r_task       <= '0;
         r_result     <= '0;
         r_bad_opcode <= 1'b0;
         r_conflict   <= 1'b0;
         r_timeout    <= 1'b0;
         r_wd_cnt     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_bad_opcode <= w_accept && (w_sel == '0);
         if (w_accept)  r_task   <= task_i;
         if (w_capture) r_result <= w_owner_result;
         if ((w_req & ~r_owner) != '0) r_conflict <= 1'b1;
         if (w_accept) r_wd_cnt <= '0;
         else if ((r_owner != '0) && (r_wd_cnt != WD_MAX)) r_wd_cnt <= r_wd_cnt + 1'b1;
         if ((r_owner != '0) && (r_wd_cnt == WD_LAST)) r_timeout <= 1'b1;
      end
   end

   assign eng_task_o   = r_task;
   assign result_o     = r_result;
   assign bad_opcode_o = r_bad_opcode;
   assign conflict_o   = r_conflict;
   assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_data_table_engine_sched.sv
// Directed bench for data_table_engine_sched: engine results are queued when
// driven and compared when result_valid_o appears.
module tb_data_table_engine_sched;
   import data_table_engine_sched_pkg::*;

   localparam int AW = TABLE_ADDR_WIDTH;

   logic                    clk = 1'b0;
   logic                    rst_i;
   ht_pdata_t               task_i;
   logic                    task_valid_i;
   logic                    task_ready_o;
   ht_pdata_t               eng_task_o;
   logic [2:0]              eng_task_valid_o;
   logic [2:0]              eng_task_ready_i;
   ht_result_t [2:0]        eng_result_i;
   logic [2:0]              eng_result_valid_i;
   logic [2:0]              eng_result_ready_o;
   logic [2:0][AW-1:0]      eng_rd_addr_i;
   logic [2:0]              eng_rd_en_i;
   logic [2:0][AW-1:0]      eng_wr_addr_i;
   ram_data_t [2:0]         eng_wr_data_i;
   logic [2:0]              eng_wr_en_i;
   logic [AW-1:0]           rd_addr_o;
   logic                    rd_en_o;
   logic [AW-1:0]           wr_addr_o;
   ram_data_t               wr_data_o;
   logic                    wr_en_o;
   ht_result_t              result_o;
   logic                    result_valid_o;
   logic                    result_ready_i;
   logic                    bad_opcode_o;
   logic                    conflict_o;
   logic                    timeout_o;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   ht_result_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_table_engine_sched #(
      .RAM_LATENCY    (2),
      .A_WIDTH        (AW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .task_i             (task_i),
      .task_valid_i       (task_valid_i),
      .task_ready_o       (task_ready_o),
      .eng_task_o         (eng_task_o),
      .eng_task_valid_o   (eng_task_valid_o),
      .eng_task_ready_i   (eng_task_ready_i),
      .eng_result_i       (eng_result_i),
      .eng_result_valid_i (eng_result_valid_i),
      .eng_result_ready_o (eng_result_ready_o),
      .eng_rd_addr_i      (eng_rd_addr_i),
      .eng_rd_en_i        (eng_rd_en_i),
      .eng_wr_addr_i      (eng_wr_addr_i),
      .eng_wr_data_i      (eng_wr_data_i),
      .eng_wr_en_i        (eng_wr_en_i),
      .rd_addr_o          (rd_addr_o),
      .rd_en_o            (rd_en_o),
      .wr_addr_o          (wr_addr_o),
      .wr_data_o          (wr_data_o),
      .wr_en_o            (wr_en_o),
      .result_o           (result_o),
      .result_valid_o     (result_valid_o),
      .result_ready_i     (result_ready_i),
      .bad_opcode_o       (bad_opcode_o),
      .conflict_o         (conflict_o),
      .timeout_o          (timeout_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      ht_result_t e;
      e = '0;
      assert (exp_q.size() != 0) else begin
         n_err++;
         $error("FAIL %s_sb: observed empty scoreboard expected 1 entry", tag);
      end
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk(tag, 64'(result_o), 64'(e));
   endtask

   task automatic clr_eng();
      eng_task_ready_i   = '0;
      eng_result_i       = '0;
      eng_result_valid_i = '0;
      eng_rd_addr_i      = '0;
      eng_rd_en_i        = '0;
      eng_wr_addr_i      = '0;
      eng_wr_data_i      = '0;
      eng_wr_en_i        = '0;
   endtask

   task automatic do_reset();
      rst_i        = 1'b1;
      task_valid_i = 1'b0;
      clr_eng();
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
   endtask

   function automatic ht_pdata_t mk_task(input ht_opcode_e op, input logic [AW-1:0] bkt,
                                         input logic [15:0] key);
      ht_pdata_t p;
      p.cmd.opcode = op;
      p.cmd.key    = key;
      p.cmd.value  = {key, ~key};
      p.bucket     = bkt;
      return p;
   endfunction

   function automatic ht_result_t mk_res(input logic f, input logic [AW-1:0] a, input logic [31:0] v);
      ht_result_t r;
      r.found = f;
      r.addr  = a;
      r.value = v;
      return r;
   endfunction

   initial begin
      #20000;
      $display("FAIL global_timeout: simulation did not finish within bound");
      $fatal(1, "bench time limit expired");
   end

   initial begin
      ht_pdata_t  t, t2;
      ht_result_t r, r2;
      int         acc;

      rst_i          = 1'b1;
      task_i         = '0;
      task_valid_i   = 1'b0;
      result_ready_i = 1'b1;
      clr_eng();
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_task_ready", 64'(task_ready_o), 64'd1);
      chk("rst_eng_valid", 64'(eng_task_valid_o), 64'd0);
      chk("rst_result", 64'(result_o), 64'd0);
      chk("rst_eng_task", 64'(eng_task_o), 64'd0);
      chk("rst_flags", 64'({result_valid_o, bad_opcode_o, conflict_o, timeout_o, rd_en_o, wr_en_o}), 64'd0);
      rst_i = 1'b0;

      // search, result 6 cycles after dispatch handshake, result_ready held off
      @(negedge clk);
      t = mk_task(OP_SEARCH, 8'd5, 16'h1234);
      task_i = t; task_valid_i = 1'b1; eng_task_ready_i = 3'b001; result_ready_i = 1'b0;
      acc = cyc + 1;
      @(negedge clk);
      task_valid_i = 1'b0;
      chk("srch_task_valid", 64'(eng_task_valid_o), 64'b001);
      chk("srch_task_ready", 64'(task_ready_o), 64'd0);
      chk("srch_task_lock", 64'(eng_task_o), 64'(t));
      @(negedge clk);
      chk("srch_valid_1cyc", 64'(eng_task_valid_o), 64'd0);
      chk("srch_res_ready", 64'(eng_result_ready_o), 64'b001);
      repeat (6) @(negedge clk);
      chk("srch_no_early_rv", 64'(result_valid_o), 64'd0);
      r = mk_res(1'b1, 8'h05, 32'hCAFE_0001);
      eng_result_i[0] = r; eng_result_valid_i = 3'b001;
      exp_q.push_back(r);
      @(negedge clk);
      clr_eng();
      chk("srch_rv", 64'(result_valid_o), 64'd1);
      chk("srch_latency", 64'(cyc - acc), 64'd8);
      pop_check("srch_result");
      @(negedge clk);
      chk("srch_rv_hold", 64'(result_valid_o), 64'd1);
      chk("srch_res_stable", 64'(result_o), 64'(r));
      chk("srch_ready_hold", 64'(task_ready_o), 64'd0);
      result_ready_i = 1'b1;
      @(negedge clk);
      chk("srch_rv_drop", 64'(result_valid_o), 64'd0);
      chk("srch_idle_ready", 64'(task_ready_o), 64'd1);

      // delete: read then write at 0x12 with write in the capture cycle
      t = mk_task(OP_DELETE, 8'h12, 16'h00AA);
      task_i = t; task_valid_i = 1'b1; eng_task_ready_i = 3'b100;
      @(negedge clk);
      task_valid_i = 1'b0;
      chk("del_task_valid", 64'(eng_task_valid_o), 64'b100);
      @(negedge clk);
      eng_rd_en_i = 3'b100; eng_rd_addr_i[2] = 8'h12; eng_rd_addr_i[0] = 8'h77;
      #1;
      chk("del_rd_en", 64'(rd_en_o), 64'd1);
      chk("del_rd_addr", 64'(rd_addr_o), 64'h12);
      chk("del_wr_en_idle", 64'(wr_en_o), 64'd0);
      @(negedge clk);
      eng_rd_en_i = '0;
      eng_wr_en_i = 3'b100; eng_wr_addr_i[2] = 8'h12; eng_wr_data_i[2] = '0;
      eng_wr_addr_i[0] = 8'h99; eng_wr_data_i[0] = 48'hDEAD_BEEF_0000;
      r = mk_res(1'b1, 8'h12, 32'h0000_00AA);
      eng_result_i[2] = r; eng_result_valid_i = 3'b100;
      exp_q.push_back(r);
      #1;
      chk("del_wr_en", 64'(wr_en_o), 64'd1);
      chk("del_wr_addr", 64'(wr_addr_o), 64'h12);
      chk("del_wr_data", 64'(wr_data_o), 64'd0);
      @(negedge clk);
      clr_eng();
      #1;
      chk("del_rv", 64'(result_valid_o), 64'd1);
      pop_check("del_result");
      chk("del_ram_off", 64'({rd_en_o, wr_en_o}), 64'd0);
      chk("del_no_conflict", 64'(conflict_o), 64'd0);
      @(negedge clk);

      // back-to-back insert then search with task_valid_i held high
      t  = mk_task(OP_INSERT, 8'h34, 16'h5A5A);
      t2 = mk_task(OP_SEARCH, 8'h34, 16'h5A5A);
      task_i = t; task_valid_i = 1'b1; eng_task_ready_i = 3'b010;
      @(negedge clk);
      chk("b2b_ins_valid", 64'(eng_task_valid_o), 64'b010);
      chk("b2b_ready_disp", 64'(task_ready_o), 64'd0);
      task_i = t2;
      @(negedge clk);
      chk("b2b_ready_busy", 64'(task_ready_o), 64'd0);
      chk("b2b_no_redispatch", 64'(eng_task_valid_o), 64'd0);
      eng_wr_en_i = 3'b010; eng_wr_addr_i[1] = 8'h34; eng_wr_data_i[1] = 48'h0000_0000_ABCD;
      r = mk_res(1'b0, 8'h34, 32'h1111_2222);
      eng_result_i[1] = r; eng_result_valid_i = 3'b010;
      exp_q.push_back(r);
      #1;
      chk("b2b_wr_addr", 64'(wr_addr_o), 64'h34);
      chk("b2b_wr_data", 64'(wr_data_o), 64'hABCD);
      @(negedge clk);
      clr_eng();
      chk("b2b_ready_result", 64'(task_ready_o), 64'd0);
      chk("b2b_rv1", 64'(result_valid_o), 64'd1);
      pop_check("b2b_result1");
      @(negedge clk);
      eng_task_ready_i = 3'b001;
      chk("b2b_idle_ready", 64'(task_ready_o), 64'd1);
      chk("b2b_lock_kept", 64'(eng_task_o), 64'(t));
      @(negedge clk);
      task_valid_i = 1'b0;
      chk("b2b_srch_valid", 64'(eng_task_valid_o), 64'b001);
      chk("b2b_srch_lock", 64'(eng_task_o), 64'(t2));
      @(negedge clk);
      r2 = mk_res(1'b1, 8'h34, 32'h3333_4444);
      eng_result_i[0] = r2; eng_result_valid_i = 3'b001;
      exp_q.push_back(r2);
      @(negedge clk);
      clr_eng();
      chk("b2b_rv2", 64'(result_valid_o), 64'd1);
      pop_check("b2b_result2");
      @(negedge clk);

      // unsupported opcode
      task_i = mk_task(OP_NOP, 8'h01, 16'hFFFF); task_valid_i = 1'b1;
      @(negedge clk);
      task_valid_i = 1'b0;
      chk("bad_pulse", 64'(bad_opcode_o), 64'd1);
      chk("bad_no_dispatch", 64'(eng_task_valid_o), 64'd0);
      chk("bad_ready", 64'(task_ready_o), 64'd1);
      @(negedge clk);
      chk("bad_pulse_end", 64'(bad_opcode_o), 64'd0);
      chk("bad_still_idle", 64'({task_ready_o, eng_task_valid_o}), 64'b1000);

      // watchdog: engine never returns a result
      do_reset();
      task_i = mk_task(OP_INSERT, 8'h40, 16'h0040); task_valid_i = 1'b1; eng_task_ready_i = 3'b010;
      @(negedge clk);
      task_valid_i = 1'b0;
      repeat (7) @(negedge clk);
      chk("wd_before", 64'(timeout_o), 64'd0);
      @(negedge clk);
      chk("wd_rise", 64'(timeout_o), 64'd1);
      chk("wd_still_busy", 64'(eng_result_ready_o), 64'b010);
      @(negedge clk);
      chk("wd_sticky", 64'(timeout_o), 64'd1);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_ready", 64'(task_ready_o), 64'd1);
      chk("arst_outs", 64'({timeout_o, eng_result_ready_o, eng_task_valid_o, result_valid_o}), 64'd0);
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      chk("arst_idle", 64'({task_ready_o, rd_en_o, wr_en_o, result_valid_o}), 64'b1000);

      // conflict: search engine requests while insert owns the RAM
      task_i = mk_task(OP_INSERT, 8'h21, 16'h0021); task_valid_i = 1'b1; eng_task_ready_i = 3'b010;
      @(negedge clk);
      task_valid_i = 1'b0;
      eng_rd_en_i = 3'b001; eng_rd_addr_i[0] = 8'h55;
      #1;
      chk("cfl_not_fwd", 64'(rd_en_o), 64'd0);
      chk("cfl_pre", 64'(conflict_o), 64'd0);
      @(negedge clk);
      chk("cfl_set", 64'(conflict_o), 64'd1);
      eng_rd_en_i = 3'b011; eng_rd_addr_i[1] = 8'h21;
      #1;
      chk("cfl_owner_rd", 64'(rd_en_o), 64'd1);
      chk("cfl_owner_addr", 64'(rd_addr_o), 64'h21);
      @(negedge clk);
      eng_rd_en_i = 3'b010;
      r = mk_res(1'b1, 8'h21, 32'h0000_0021);
      eng_result_i[1] = r; eng_result_valid_i = 3'b010;
      exp_q.push_back(r);
      @(negedge clk);
      clr_eng();
      pop_check("cfl_result");
      @(negedge clk);
      chk("cfl_sticky", 64'(conflict_o), 64'd1);
      do_reset();
      chk("cfl_cleared", 64'(conflict_o), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_table_engine_sched.md
Name: data_table_engine_sched

Overview:
- Front-end scheduler for the data table.
- Accepts one pipelined task (ht_pdata_t) at a time and dispatches it to the search, insert or delete engine by opcode.
- Grants the single data-RAM read/write port to that engine only, and returns its result through a registered output stage.
- Serialises all data-table operations so engines never contend for the RAM or corrupt chains mid-walk.

Parameters:
- RAM_LATENCY, 2, data RAM read latency; informational only, no internal use.
- A_WIDTH, TABLE_ADDR_WIDTH, data RAM address width.
- TIMEOUT_CYCLES, 1024, maximum cycles an engine may hold the RAM before the watchdog flags it; must be ≥2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- task_i  in  ht_pdata_t  incoming task
- task_valid_i  in  1  task valid
- task_ready_o  out  1  task ready
- eng_task_o  out  ht_pdata_t  locked task, shared by all engines
- eng_task_valid_o  out  3  one-hot task valid; bit 0 search, 1 insert, 2 delete
- eng_task_ready_i  in  3  per-engine task ready
- eng_result_i  in  3 x ht_result_t  per-engine result
- eng_result_valid_i  in  3  per-engine result valid
- eng_result_ready_o  out  3  per-engine result ready
- eng_rd_addr_i  in  3 x A_WIDTH  engine read addresses
- eng_rd_en_i  in  3  engine read enables
- eng_wr_addr_i  in  3 x A_WIDTH  engine write addresses
- eng_wr_data_i  in  3 x ram_data_t  engine write data
- eng_wr_en_i  in  3  engine write enables
- rd_addr_o  out  A_WIDTH  data RAM read address
- rd_en_o  out  1  data RAM read enable
- wr_addr_o  out  A_WIDTH  data RAM write address
- wr_data_o  out  ram_data_t  data RAM write data
- wr_en_o  out  1  data RAM write enable
- result_o  out  ht_result_t  registered result
- result_valid_o  out  1  result valid
- result_ready_i  in  1  result ready
- bad_opcode_o  out  1  one-cycle pulse when a task with an unsupported opcode is dropped
- conflict_o  out  1  sticky: a non-owner engine asserted rd_en or wr_en
- timeout_o  out  1  sticky: watchdog expired

Behaviour:
- Reset is rst_i, asynchronous, active-high; clock is clk_i.
- Reset values: state IDLE_S, owner none, all valids/enables 0, result_o '0, task lock '0, bad_opcode_o/conflict_o/timeout_o 0, watchdog counter 0.
- FSM states: IDLE_S, DISPATCH_S, BUSY_S, RESULT_S.
- IDLE_S:
  - task_ready_o=1; all other states task_ready_o=0.
  - On task_valid_i, lock task_i and decode task_i.cmd.opcode: OP_SEARCH→0, OP_INSERT→1, OP_DELETE→2.
  - Valid opcode → owner=sel, go to DISPATCH_S.
  - Any other opcode → pulse bad_opcode_o for one cycle, stay in IDLE_S, no engine sees the task.
- DISPATCH_S:
  - eng_task_valid_o[owner]=1, other bits 0; held until eng_task_ready_i[owner].
  - Then go to BUSY_S.
  - RAM mux already selects owner in this state.
- BUSY_S:
  - eng_result_ready_o[owner]=1.
  - On eng_result_valid_i[owner], capture eng_result_i[owner] into result_o and go to RESULT_S.
  - The RAM mux stays on owner during the capture cycle; the delete engine writes in its final state.
- RESULT_S:
  - result_valid_o=1, held stable until result_ready_i, then go to IDLE_S.
  - Owner is released on entry; RAM enables are 0.
- RAM mux (combinational):
  - In DISPATCH_S/BUSY_S, rd_*/wr_* outputs = owner's inputs.
  - Otherwise rd_en_o=wr_en_o=0; addresses/data are don't-care, driven 0.
  - RAM read data is not routed here; it fans out to the engines directly.
- Latency:
  - Task accept to eng_task_valid_o: 1 cycle.
  - Engine result valid to result_valid_o: 1 cycle.
  - Minimum accept-to-accept spacing: 4 cycles.
- conflict_o: set when, in any state, eng_rd_en_i[i] or eng_wr_en_i[i] is high for i≠owner, or any enable is high while no owner exists. Cleared only by reset. The offending request is never forwarded.
- Watchdog:
  - Counter clears on entry to DISPATCH_S and increments each cycle in DISPATCH_S/BUSY_S, saturating.
  - When it reaches TIMEOUT_CYCLES, set timeout_o (sticky). The FSM does not abort; it keeps waiting.
- Non-owner engines: eng_result_ready_o bits are 0. Their result valids are ignored and are not flagged.
- Reset mid-operation: everything returns to reset values immediately. Engines are reset by the same rst_i; no partial write is issued after reset deasserts.

Test Plan:
- Search task, opcode OP_SEARCH, bucket 5; search engine ready immediately, result after 6 cycles → eng_task_valid_o=3'b001 for 1 cycle; result_o equals the engine result 1 cycle later; total accept-to-result 8 cycles.
- Delete task; engine drives rd_en@addr 0x12 then wr_en@addr 0x12 with data '0 in its result cycle → rd_en_o/wr_en_o mirror it with the same addr/data; wr_en_o is seen in the capture cycle.
- Back-to-back tasks insert then search, task_valid_i held high → second task accepted only after the first result handshake; task_ready_o=0 in DISPATCH_S/BUSY_S/RESULT_S.
- Unsupported opcode → bad_opcode_o high exactly 1 cycle; eng_task_valid_o stays 0; task_ready_o stays 1.
- Owner=insert, search engine pulses rd_en_i → rd_en_o follows insert only; conflict_o=1 and stays 1 until reset.
- TIMEOUT_CYCLES=8, engine never returns a result → timeout_o rises 8 cycles after DISPATCH_S entry. Async reset mid-BUSY_S → next cycle is IDLE_S with all outputs 0 and task_ready_o=1.
